// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 block chain.
package sha1_pkg;

  typedef logic [511:0] block_t;

  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFF     = 56;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    LEN,
    EMIT
  } pad_state_e;

endpackage

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a byte stream big-endian into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit message bit length, and hands the
// blocks downstream over a valid/ready handshake.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int MAX_BYTES_W = 61
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [7:0]   in_data_i,
  input  logic         in_valid_i,
  input  logic         in_last_i,
  output logic         in_ready_o,
  output block_t       block_o,
  output logic         block_valid_o,
  output logic         block_last_o,
  input  logic         block_ready_i
);

  pad_state_e             state_q, state_d;
  logic [6:0]             idx_q;
  logic [MAX_BYTES_W-1:0] cnt_q;
  block_t                 blk_q, blk_d;
  logic                   fin_q;
  logic                   pend_pad_q;
  logic                   len_owed_q;

  logic                   accept;
  logic [6:0]             idx_inc;
  logic                   full;
  logic                   len_fits;
  logic [63:0]            len_bits;
  block_t                 len_blk;
  logic [BLOCK_BYTES-1:0] lane_we;

  assign accept   = in_valid_i & in_ready_o;
  assign idx_inc  = idx_q + 7'd1;
  assign full     = (idx_inc == 7'(BLOCK_BYTES));
  assign len_fits = (idx_q < 7'(LEN_OFF));
  assign len_bits = 64'({cnt_q, 3'b000});
  assign len_blk  = {{(512 - 64){1'b0}}, len_bits};
  assign block_o  = blk_q;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FILL;
    else         state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: every combinationally assigned signal gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (full)           state_d = EMIT;
          else if (in_last_i) state_d = PAD;
        end
      end
      PAD:  state_d = EMIT;
      LEN:  state_d = EMIT;
      EMIT: begin
        if (block_ready_i) begin
          if (pend_pad_q)      state_d = PAD;
          else if (len_owed_q) state_d = LEN;
          else                 state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs, decoded from state only so they are glitch-free and
  // stable while a block waits for the consumer.
  always_comb begin
    in_ready_o    = (state_q == FILL);
    block_valid_o = (state_q == EMIT);
    block_last_o  = (state_q == EMIT) && fin_q;
  end

  // Byte-lane write enables and next buffer contents, one lane per block byte.
  always_comb begin
    blk_d   = blk_q;
    lane_we = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      logic [7:0] lane_data;
      lane_data = 8'h00;
      unique case (state_q)
        FILL: begin
          if (accept && idx_q == 7'(k)) begin
            lane_we[k] = 1'b1;
            lane_data  = in_data_i;
          end
        end
        PAD: begin
          // 0x80 marker at idx, zeros above it, length in the tail if it fits.
          if (idx_q == 7'(k)) begin
            lane_we[k] = 1'b1;
            lane_data  = 8'h80;
          end else if (idx_q < 7'(k)) begin
            lane_we[k] = 1'b1;
            if (k >= LEN_OFF && len_fits) lane_data = len_blk[8*(63-k) +: 8];
          end
        end
        LEN: begin
          lane_we[k] = 1'b1;
          if (k >= LEN_OFF) lane_data = len_blk[8*(63-k) +: 8];
        end
        EMIT: begin
          // Clear whenever idx returns to 0; a LEN block rewrites every lane.
          if (block_ready_i && !len_owed_q) lane_we[k] = 1'b1;
        end
        default: ;
      endcase
      if (lane_we[k]) blk_d[8*(63-k) +: 8] = lane_data;
    end
  end

  // Block buffer.
  // NOTE: the buffer is reset because it drives block_o directly and must
  // read zero out of reset; storage that never reaches an output needs none.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) blk_q <= '0;
    else         blk_q <= blk_d;
  end

  // Byte index, message byte counter and block-sequencing flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      pend_pad_q <= 1'b0;
      len_owed_q <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            idx_q <= idx_inc;
            cnt_q <= cnt_q + MAX_BYTES_W'(1);
            if (full) begin
              fin_q      <= 1'b0;
              pend_pad_q <= in_last_i;
            end
          end
        end
        PAD: begin
          fin_q      <= len_fits;
          len_owed_q <= !len_fits;
        end
        LEN: begin
          fin_q      <= 1'b1;
          len_owed_q <= 1'b0;
        end
        EMIT: begin
          if (block_ready_i) begin
            if (pend_pad_q) begin
              pend_pad_q <= 1'b0;
              idx_q      <= '0;
            end else if (len_owed_q) begin
              idx_q <= idx_q;
            end else if (fin_q) begin
              cnt_q <= '0;
              idx_q <= '0;
              fin_q <= 1'b0;
            end else begin
              idx_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder: known messages with hand-built blocks,
// latency, backpressure, back-to-back messages and mid-message reset.
module tb_sha1_padder;
  import sha1_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  block_t     block;
  logic       block_valid;
  logic       block_last;
  logic       block_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg_q[$];
  block_t     got_blk[$];
  bit         got_last[$];
  int         first_acc_cyc, last_acc_cyc, first_valid_cyc;
  bit         timeout, stall_changed, stall_inready, valid_dropped;

  sha1_padder #(.MAX_BYTES_W(61)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_last_i    (in_last),
    .in_ready_o   (in_ready),
    .block_o      (block),
    .block_valid_o(block_valid),
    .block_last_o (block_last),
    .block_ready_i(block_ready)
  );

  always #5 clk = ~clk;

  // Drives msg_q byte by byte and collects blocks until the last one is
  // consumed; ready is withheld for the first 'stall' valid cycles.
  task automatic run_msg(input int stall);
    int     pos = 0;
    int     c = 0;
    int     stalled = 0;
    bit     done = 0;
    bit     prev_wait = 0;
    block_t held = '0;
    bit     held_last = 0;
    got_blk.delete();
    got_last.delete();
    first_acc_cyc   = -1;
    last_acc_cyc    = -1;
    first_valid_cyc = -1;
    timeout = 0; stall_changed = 0; stall_inready = 0; valid_dropped = 0;
    while (!done && c < 2000) begin
      @(negedge clk);
      if (pos < msg_q.size()) begin
        in_valid = 1'b1;
        in_data  = msg_q[pos];
        in_last  = (pos == msg_q.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
      end
      if (prev_wait && !block_valid) valid_dropped = 1;
      if (block_valid && stalled < stall) begin
        if (stalled == 0) begin
          held      = block;
          held_last = block_last;
        end else if (block !== held || block_last !== held_last) begin
          stall_changed = 1;
        end
        block_ready = 1'b0;
        stalled++;
      end else begin
        block_ready = 1'b1;
      end
      #1;
      if (block_valid && in_ready) stall_inready = 1;
      if (in_valid && in_ready) begin
        if (first_acc_cyc < 0) first_acc_cyc = c;
        if (in_last) last_acc_cyc = c;
        pos++;
      end
      prev_wait = block_valid && !block_ready;
      if (block_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = c;
        if (block_ready) begin
          got_blk.push_back(block);
          got_last.push_back(block_last);
          if (block_last) done = 1;
        end
      end
      c++;
    end
    if (!done) timeout = 1;
  endtask

  function automatic block_t abc_block();
    block_t e = '0;
    e[511 -: 32] = 32'h61626380;
    e[63:0]      = 64'h18;
    return e;
  endfunction

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = 0; in_last = 0; block_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (block !== '0) begin errors++; $display("FAIL reset_block: got %h expected 0", block); end
    checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", block_valid); end
    checks++; if (block_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", block_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    load_abc();
    run_msg(0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL abc_timeout: got %b expected 0", timeout); end
    checks++; if (got_blk.size() != 1) begin errors++; $display("FAIL abc_count: got %0d expected 1", got_blk.size()); end
    if (got_blk.size() >= 1) begin
      checks++; if (got_blk[0] !== abc_block()) begin errors++; $display("FAIL abc_block: got %h expected %h", got_blk[0], abc_block()); end
      checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL abc_last: got %b expected 1", got_last[0]); end
    end
    checks++; if (first_valid_cyc != last_acc_cyc + 2) begin errors++; $display("FAIL abc_latency: got %0d expected %0d", first_valid_cyc, last_acc_cyc + 2); end
  endtask

  task automatic test_55_bytes();
    block_t e = '0;
    msg_q.delete();
    for (int i = 0; i < 55; i++) msg_q.push_back(8'h00);
    e[511 - 8*55 -: 8] = 8'h80;
    e[63:0] = 64'h1B8;
    run_msg(0);
    checks++; if (got_blk.size() != 1) begin errors++; $display("FAIL b55_count: got %0d expected 1", got_blk.size()); end
    if (got_blk.size() >= 1) begin
      checks++; if (got_blk[0] !== e) begin errors++; $display("FAIL b55_block: got %h expected %h", got_blk[0], e); end
      checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL b55_last: got %b expected 1", got_last[0]); end
    end
  endtask

  task automatic test_56_bytes();
    block_t e1 = '0;
    block_t e2 = '0;
    msg_q.delete();
    for (int i = 0; i < 56; i++) begin
      msg_q.push_back(8'(i + 1));
      e1[511 - 8*i -: 8] = 8'(i + 1);
    end
    e1[511 - 8*56 -: 8] = 8'h80;
    e2[63:0] = 64'h1C0;
    run_msg(0);
    checks++; if (got_blk.size() != 2) begin errors++; $display("FAIL b56_count: got %0d expected 2", got_blk.size()); end
    if (got_blk.size() >= 2) begin
      checks++; if (got_blk[0] !== e1) begin errors++; $display("FAIL b56_block1: got %h expected %h", got_blk[0], e1); end
      checks++; if (got_last[0] !== 1'b0) begin errors++; $display("FAIL b56_last1: got %b expected 0", got_last[0]); end
      checks++; if (got_blk[1] !== e2) begin errors++; $display("FAIL b56_block2: got %h expected %h", got_blk[1], e2); end
      checks++; if (got_last[1] !== 1'b1) begin errors++; $display("FAIL b56_last2: got %b expected 1", got_last[1]); end
    end
  endtask

  task automatic test_64_bytes();
    block_t e1 = '0;
    block_t e2 = '0;
    msg_q.delete();
    for (int i = 0; i < 64; i++) begin
      msg_q.push_back(8'(i));
      e1[511 - 8*i -: 8] = 8'(i);
    end
    e2[511 -: 8] = 8'h80;
    e2[63:0]     = 64'h200;
    run_msg(0);
    checks++; if (got_blk.size() != 2) begin errors++; $display("FAIL b64_count: got %0d expected 2", got_blk.size()); end
    checks++; if (first_valid_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL b64_latency: got %0d expected %0d", first_valid_cyc, last_acc_cyc + 1); end
    if (got_blk.size() >= 2) begin
      checks++; if (got_blk[0] !== e1) begin errors++; $display("FAIL b64_block1: got %h expected %h", got_blk[0], e1); end
      checks++; if (got_last[0] !== 1'b0) begin errors++; $display("FAIL b64_last1: got %b expected 0", got_last[0]); end
      checks++; if (got_blk[1] !== e2) begin errors++; $display("FAIL b64_block2: got %h expected %h", got_blk[1], e2); end
      checks++; if (got_last[1] !== 1'b1) begin errors++; $display("FAIL b64_last2: got %b expected 1", got_last[1]); end
    end
  endtask

  task automatic test_backpressure();
    load_abc();
    run_msg(10);
    checks++; if (got_blk.size() != 1) begin errors++; $display("FAIL bp_count: got %0d expected 1", got_blk.size()); end
    checks++; if (stall_changed !== 1'b0) begin errors++; $display("FAIL bp_stable: got %b expected 0", stall_changed); end
    checks++; if (stall_inready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", stall_inready); end
    checks++; if (valid_dropped !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", valid_dropped); end
    if (got_blk.size() >= 1) begin
      checks++; if (got_blk[0] !== abc_block()) begin errors++; $display("FAIL bp_block: got %h expected %h", got_blk[0], abc_block()); end
    end
  endtask

  task automatic test_back_to_back();
    load_abc();
    run_msg(0);
    run_msg(0);
    checks++; if (first_acc_cyc != 0) begin errors++; $display("FAIL b2b_first_accept: got %0d expected 0", first_acc_cyc); end
    checks++; if (got_blk.size() != 1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", got_blk.size()); end
    if (got_blk.size() >= 1) begin
      checks++; if (got_blk[0] !== abc_block()) begin errors++; $display("FAIL b2b_block: got %h expected %h", got_blk[0], abc_block()); end
    end
  endtask

  task automatic test_reset_mid();
    block_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    rst_n = 1'b0;
    #1;
    checks++; if (block !== '0) begin errors++; $display("FAIL mid_rst_block: got %h expected 0", block); end
    checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", block_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_abc();
    run_msg(0);
    checks++; if (got_blk.size() != 1) begin errors++; $display("FAIL mid_rst_count: got %0d expected 1", got_blk.size()); end
    if (got_blk.size() >= 1) begin
      checks++; if (got_blk[0] !== abc_block()) begin errors++; $display("FAIL mid_rst_block_out: got %h expected %h", got_blk[0], abc_block()); end
      checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_last: got %b expected 1", got_last[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_55_bytes();
    test_56_bytes();
    test_64_bytes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
